// File: rtl/ram_rd_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | ram_rd_pkg : shared widths, FSM states and FIFO entry for ram_rd_stream |
// | Revision   : 1.0                                                       |
// +-----------------------------------------------------------------------+
package ram_rd_pkg;

  localparam int AW         = 8;
  localparam int DW         = 9;
  localparam int FIFO_DEPTH = 3;
  localparam int OCC_W      = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic          last;
    logic [DW-1:0] data;
  } fifo_entry_t;

  // A word whose 9 bits XOR to 1 is flagged as a parity error.
  function automatic logic odd_parity(input logic [DW-1:0] word);
    return ^word;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ram_rd_stream_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | ram_rd_stream_if : command channel and output word stream             |
// | Revision         : 1.0                                                |
// +-----------------------------------------------------------------------+
interface ram_rd_stream_if #(
  parameter int AW = 8,
  parameter int DW = 9
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_base;
  logic [AW:0]   cmd_len;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;

  modport master (
    output cmd_valid, cmd_base, cmd_len, out_ready,
    input  cmd_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  cmd_valid, cmd_base, cmd_len, out_ready,
    output cmd_ready, out_valid, out_data, out_last
  );
endinterface
`default_nettype wire

// File: rtl/ram_rd_fifo.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | ram_rd_fifo : small synchronous FIFO with occupancy output for credit |
// | Revision    : 1.0                                                     |
// +-----------------------------------------------------------------------+
module ram_rd_fifo #(
  parameter int DEPTH = 3,
  parameter int WIDTH = 10,
  parameter int OCC_W = $clog2(DEPTH + 1)
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             i_push,
  input  wire logic [WIDTH-1:0] i_data,
  input  wire logic             i_pop,
  output logic      [WIDTH-1:0] o_data,
  output logic                  o_empty,
  output logic      [OCC_W-1:0] o_occ
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] c_last_ptr = PTR_W'(DEPTH - 1);
  localparam logic [OCC_W-1:0] c_full_occ = OCC_W'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [OCC_W-1:0] r_occ;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_occ == '0);
  assign o_occ     = r_occ;
  assign o_data    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty;
  // A push into a full FIFO is only legal when the head leaves the same cycle.
  assign w_do_push = i_push && ((r_occ != c_full_occ) || w_do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= (r_wr_ptr == c_last_ptr) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= (r_rd_ptr == c_last_ptr) ? '0 : r_rd_ptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_occ <= r_occ + 1'b1;
        2'b01:   r_occ <= r_occ - 1'b1;
        default: r_occ <= r_occ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/ram_rd_stream.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | ram_rd_stream : burst reader for a latency-1 RAM port, streamed out   |
// | Optional macro RAM_RD_STREAM_PARITY_EN builds the sticky par_err flag |
// | Revision      : 1.0                                                   |
// +-----------------------------------------------------------------------+
module ram_rd_stream
  import ram_rd_pkg::*;
(
  input  wire logic          r0clk,
  input  wire logic          r0rst_n,
  ram_rd_stream_if.slave     bus,
  output logic      [AW-1:0] r0addr,
  output logic               r0re,
  input  wire logic [DW-1:0] r0do,
  output logic               busy,
  output logic               par_err
);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [AW-1:0]   r_addr;
  logic [AW:0]     r_remain;
  logic            r_inflight;
  logic            r_inflight_last;
  logic            w_load;
  logic            w_issue;
  logic            w_credit_ok;
  logic            w_pop;
  logic            w_empty;
  logic [OCC_W-1:0] w_occ;
  fifo_entry_t     w_push_entry;
  fifo_entry_t     w_head;

  // Credit counts the word still in flight from the RAM so the FIFO can never overflow.
  assign w_credit_ok = ({1'b0, w_occ} + {{OCC_W{1'b0}}, r_inflight}) < (OCC_W + 1)'(FIFO_DEPTH);
  assign w_pop       = bus.out_valid && bus.out_ready;

  always_ff @(posedge r0clk or negedge r0rst_n) begin
    if (!r0rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_issue     = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.cmd_valid && (bus.cmd_len != '0)) begin
          w_load      = 1'b1;
          w_state_nxt = READ;
        end
      end
      READ: begin
        if (w_credit_ok) begin
          w_issue = 1'b1;
          if (r_remain == (AW + 1)'(1)) begin
            w_state_nxt = DRAIN;
          end
        end
      end
      DRAIN: begin
        // Leave as the final word is handed over so busy drops on the next cycle.
        if (!r_inflight && (w_empty || ((w_occ == OCC_W'(1)) && w_pop))) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge r0clk or negedge r0rst_n) begin
    if (!r0rst_n) begin
      r_addr          <= '0;
      r_remain        <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
    end else begin
      r_inflight      <= w_issue;
      r_inflight_last <= w_issue && (r_remain == (AW + 1)'(1));
      if (w_load) begin
        r_addr   <= bus.cmd_base;
        r_remain <= bus.cmd_len;
      end else if (w_issue) begin
        r_addr   <= r_addr + 1'b1;
        r_remain <= r_remain - 1'b1;
      end
    end
  end

  assign w_push_entry = '{last: r_inflight_last, data: r0do};

  ram_rd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(fifo_entry_t)),
    .OCC_W (OCC_W)
  ) u_fifo (
    .clk     (r0clk),
    .rst_n   (r0rst_n),
    .i_push  (r_inflight),
    .i_data  (w_push_entry),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_empty (w_empty),
    .o_occ   (w_occ)
  );

  assign r0addr        = r_addr;
  assign r0re          = w_issue;
  assign busy          = (r_state != IDLE);
  assign bus.cmd_ready = (r_state == IDLE);
  assign bus.out_valid = !w_empty;
  assign bus.out_data  = w_head.data;
  assign bus.out_last  = w_head.last;

`ifdef RAM_RD_STREAM_PARITY_EN
  logic r_par_err;

  always_ff @(posedge r0clk or negedge r0rst_n) begin
    if (!r0rst_n) begin
      r_par_err <= 1'b0;
    end else if (w_load) begin
      r_par_err <= 1'b0;
    end else if (r_inflight && odd_parity(r0do)) begin
      r_par_err <= 1'b1;
    end
  end

  assign par_err = r_par_err;
`else
  assign par_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ram_rd_stream.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_ram_rd_stream : randomized bench with a queue-based burst model    |
// | Revision         : 1.0                                                |
// +-----------------------------------------------------------------------+
module tb_ram_rd_stream;

  logic       r0clk;
  logic       r0rst_n;
  logic [7:0] r0addr;
  logic       r0re;
  logic [8:0] r0do;
  logic       busy;
  logic       par_err;

  ram_rd_stream_if #(.AW(8), .DW(9)) bus ();

  ram_rd_stream dut (
    .r0clk   (r0clk),
    .r0rst_n (r0rst_n),
    .bus     (bus),
    .r0addr  (r0addr),
    .r0re    (r0re),
    .r0do    (r0do),
    .busy    (busy),
    .par_err (par_err)
  );

  logic [8:0] mem [256];

  initial r0clk = 1'b0;
  always #5 r0clk = ~r0clk;

  // Behavioural RAM: data appears on r0do one cycle after a read enable.
  initial r0do = '0;
  always @(posedge r0clk) if (r0re) r0do <= mem[r0addr];

  int checks = 0;
  int errors = 0;

  logic [9:0] got_q [$];
  logic [9:0] exp_q [$];
  int first_valid_cyc, last_hs_cyc, busy_low_cyc, par_hi_cyc;
  int n_issue, bad_addr, unstable, max_out;
  logic par_at1, saw_busy, saw_valid, timed_out;

  function automatic int count_diffs();
    int d = 0;
    if (got_q.size() != exp_q.size()) return 1000 + got_q.size();
    foreach (got_q[i]) if (got_q[i] !== exp_q[i]) d++;
    return d;
  endfunction

  // Cycle 0 is the command handshake cycle; all timing results are relative to it.
  task automatic run_burst(input logic [7:0] base, input logic [8:0] len, input int mode);
    int cyc;
    int popped;
    int limit;
    logic stalled;
    logic [9:0] held;
    logic [7:0] exp_addr;
    got_q.delete();
    exp_q.delete();
    for (int i = 0; i < int'(len); i++)
      exp_q.push_back({(i == int'(len) - 1), mem[8'(int'(base) + i)]});
    first_valid_cyc = -1; last_hs_cyc = -1; busy_low_cyc = -1; par_hi_cyc = -1;
    n_issue = 0; bad_addr = 0; unstable = 0; max_out = 0;
    par_at1 = 1'b0; saw_busy = 1'b0; saw_valid = 1'b0; timed_out = 1'b0;
    limit = 4 * int'(len) + 50;
    exp_addr = base;
    stalled = 1'b0;
    popped = 0;
    cyc = 0;
    @(posedge r0clk); #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_base  = base;
    bus.cmd_len   = len;
    bus.out_ready = (mode == 0);
    while (1) begin
      @(posedge r0clk); #1;
      cyc++;
      bus.cmd_valid = 1'b0;
      bus.out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? cyc[0] : 1'($urandom_range(0, 1));
      @(negedge r0clk);
      if (busy) saw_busy = 1'b1;
      if (par_err && par_hi_cyc < 0) par_hi_cyc = cyc;
      if (cyc == 1) par_at1 = par_err;
      if (r0re) begin
        if (r0addr !== exp_addr) bad_addr++;
        exp_addr++;
        n_issue++;
        if (n_issue - popped > max_out) max_out = n_issue - popped;
      end
      if (stalled && (!bus.out_valid || {bus.out_last, bus.out_data} !== held)) unstable++;
      stalled = bus.out_valid && !bus.out_ready;
      held    = {bus.out_last, bus.out_data};
      if (bus.out_valid) begin
        saw_valid = 1'b1;
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        if (bus.out_ready) begin
          got_q.push_back(held);
          popped++;
          last_hs_cyc = cyc;
        end
      end
      if (!busy && saw_busy && busy_low_cyc < 0) busy_low_cyc = cyc;
      if (!busy && cyc >= 4 && (saw_busy || len == 0)) break;
      if (cyc > limit) begin
        timed_out = 1'b1;
        break;
      end
    end
    bus.out_ready = 1'b1;
  endtask

  task automatic test_reset();
    logic [15:0] obs;
    r0rst_n = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_base = '0; bus.cmd_len = '0; bus.out_ready = 1'b0;
    repeat (3) @(posedge r0clk);
    @(negedge r0clk);
    obs = {bus.cmd_ready, r0re, r0addr, bus.out_valid, bus.out_last, busy, par_err, bus.out_data[0], 1'b0};
    checks++;
    if (obs !== 16'h8000 || bus.out_data !== 9'h000) begin
      errors++;
      $display("FAIL reset_values: got %h data %h, expected 8000 data 000", obs, bus.out_data);
    end
    r0rst_n = 1'b1;
  endtask

  task automatic test_basic();
    for (int i = 0; i < 256; i++) mem[i] = 9'(i);
    run_burst(8'h10, 9'd4, 0);
    checks++;
    if (timed_out !== 1'b0 || count_diffs() != 0) begin
      errors++;
      $display("FAIL basic_data: diffs %0d timeout %0d, expected 0 0", count_diffs(), timed_out);
    end
    checks++;
    if (got_q.size() == 4 && got_q[3] !== 10'h213) begin
      errors++;
      $display("FAIL basic_last_word: got %h expected 213", got_q[3]);
    end
    checks++;
    if (first_valid_cyc != 3) begin
      errors++;
      $display("FAIL basic_first_valid: got cycle %0d expected 3", first_valid_cyc);
    end
    checks++;
    if (last_hs_cyc != 6 || busy_low_cyc != 7) begin
      errors++;
      $display("FAIL basic_timing: last hs %0d busy low %0d, expected 6 7", last_hs_cyc, busy_low_cyc);
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 256; i++) mem[i] = 9'($urandom);
    run_burst(8'hFE, 9'd4, 2);
    checks++;
    if (bad_addr != 0 || n_issue != 4) begin
      errors++;
      $display("FAIL wrap_addr: bad addrs %0d issues %0d, expected 0 4", bad_addr, n_issue);
    end
    checks++;
    if (timed_out !== 1'b0 || count_diffs() != 0) begin
      errors++;
      $display("FAIL wrap_data: diffs %0d timeout %0d, expected 0 0", count_diffs(), timed_out);
    end
  endtask

  task automatic test_backpressure();
    run_burst(8'($urandom), 9'd8, 1);
    checks++;
    if (timed_out !== 1'b0 || count_diffs() != 0) begin
      errors++;
      $display("FAIL bp_data: diffs %0d timeout %0d, expected 0 0", count_diffs(), timed_out);
    end
    checks++;
    if (unstable != 0 || max_out > 3) begin
      errors++;
      $display("FAIL bp_stall: unstable %0d max outstanding %0d, expected 0 <=3", unstable, max_out);
    end
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 256; i++) mem[i] = 9'($urandom);
      run_burst(8'($urandom), 9'($urandom_range(1, 24)), 2);
      checks++;
      if (timed_out !== 1'b0 || count_diffs() != 0 || unstable != 0 || max_out > 3 || bad_addr != 0) begin
        errors++;
        $display("FAIL rand_burst%0d: diffs %0d unstable %0d maxout %0d badaddr %0d timeout %0d",
                 k, count_diffs(), unstable, max_out, bad_addr, timed_out);
      end
    end
  endtask

  task automatic test_zero_len();
    run_burst(8'($urandom), 9'd0, 0);
    checks++;
    if (n_issue != 0 || saw_valid !== 1'b0 || saw_busy !== 1'b0 || timed_out !== 1'b0) begin
      errors++;
      $display("FAIL zero_len: issues %0d valid %0d busy %0d timeout %0d, expected all 0",
               n_issue, saw_valid, saw_busy, timed_out);
    end
  endtask

  task automatic test_full_len();
    run_burst(8'h80, 9'd256, 0);
    checks++;
    if (timed_out !== 1'b0 || count_diffs() != 0 || n_issue != 256) begin
      errors++;
      $display("FAIL full_data: diffs %0d issues %0d timeout %0d, expected 0 256 0",
               count_diffs(), n_issue, timed_out);
    end
    checks++;
    if (got_q.size() != 256 || got_q[255] !== {1'b1, mem[8'h7F]} || last_hs_cyc != 258) begin
      errors++;
      $display("FAIL full_last: words %0d last hs %0d, expected 256 258", got_q.size(), last_hs_cyc);
    end
  endtask

  task automatic test_parity();
    mem[8'h20] = 9'h001;
    mem[8'h21] = 9'h003;
    run_burst(8'h20, 9'd1, 0);
`ifdef RAM_RD_STREAM_PARITY_EN
    checks++;
    if (par_hi_cyc != 3 || par_err !== 1'b1) begin
      errors++;
      $display("FAIL parity_set: rise cycle %0d now %0d, expected 3 1", par_hi_cyc, par_err);
    end
`else
    checks++;
    if (par_hi_cyc != -1 || par_err !== 1'b0) begin
      errors++;
      $display("FAIL parity_off: rise cycle %0d now %0d, expected -1 0", par_hi_cyc, par_err);
    end
`endif
    checks++;
    if (got_q.size() != 1 || got_q[0] !== 10'h201) begin
      errors++;
      $display("FAIL parity_data: words %0d, expected one word 201", got_q.size());
    end
    run_burst(8'h21, 9'd1, 0);
    checks++;
    if (par_at1 !== 1'b0 || par_hi_cyc != -1) begin
      errors++;
      $display("FAIL parity_clear: at cycle1 %0d rise %0d, expected 0 -1", par_at1, par_hi_cyc);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] obs;
    @(posedge r0clk); #1;
    bus.cmd_valid = 1'b1; bus.cmd_base = 8'h40; bus.cmd_len = 9'd16; bus.out_ready = 1'b0;
    @(posedge r0clk); #1;
    bus.cmd_valid = 1'b0;
    repeat (5) @(posedge r0clk);
    bus.out_ready = 1'b1;
    @(negedge r0clk);
    checks++;
    if (busy !== 1'b1 || bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_busy: busy %0d valid %0d, expected 1 1", busy, bus.out_valid);
    end
    #2 r0rst_n = 1'b0;
    #1;
    obs = {bus.cmd_ready, r0re, r0addr, bus.out_valid, bus.out_last, busy, par_err, 2'b00};
    checks++;
    if (obs !== 16'h8000 || bus.out_data !== 9'h000) begin
      errors++;
      $display("FAIL mid_reset_values: got %h data %h, expected 8000 data 000", obs, bus.out_data);
    end
    repeat (2) @(posedge r0clk);
    @(negedge r0clk);
    r0rst_n = 1'b1;
    run_burst(8'h00, 9'd2, 0);
    checks++;
    if (timed_out !== 1'b0 || count_diffs() != 0 || n_issue != 2) begin
      errors++;
      $display("FAIL mid_after: words %0d diffs %0d issues %0d, expected 2 0 2",
               got_q.size(), count_diffs(), n_issue);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_zero_len();
    test_full_len();
    test_parity();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
